// File: rtl/jedro_1_test_monitor.sv
// End-of-program monitor for jedro_1 benches: halt snoop on tohost, timeout, register checks.
// Optional macro JEDRO_1_TEST_MONITOR_WRCOUNT_EN enables the RUN-phase data-write counter.
module jedro_1_test_monitor #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    NUM_CHECKS     = 4,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h1000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             dmem_we_i,
    input  logic [ADDR_WIDTH-1:0]            dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]            dmem_wdata_i,
    input  logic [NUM_CHECKS*5-1:0]          exp_idx_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0] exp_val_i,
    output logic [4:0]                       rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]            rf_rdata_i,
    output logic                             done_o,
    output logic                             pass_o,
    output logic [1:0]                       fail_code_o,
    output logic [$clog2(NUM_CHECKS):0]      fail_idx_o,
    output logic [31:0]                      cycle_count_o,
    output logic [31:0]                      dmem_wr_count_o,
    output logic [1:0]                       state_o
);

    localparam int          IDX_W        = $clog2(NUM_CHECKS) + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_PROGRAM  = 2'd2;
    localparam logic [1:0] FC_MISMATCH = 2'd3;

    logic [1:0]            state;
    logic [IDX_W-1:0]      k;
    logic [4:0]            cur_idx;
    logic [DATA_WIDTH-1:0] cur_val;
    logic                  halt;
    logic                  timeout;
    logic                  enter_run;
    logic                  last_check;

    // start_i is a level sampled every edge and only honoured in IDLE or DONE;
    // done_o qualifies pass_o/fail_code_o/fail_idx_o and holds until the next start or reset.
    assign enter_run  = start_i && (state == S_IDLE || state == S_DONE);
    assign halt       = dmem_we_i && (dmem_addr_i == TOHOST_ADDR);
    assign timeout    = (cycle_count_o == TIMEOUT_LAST);
    assign last_check = (k == IDX_W'(NUM_CHECKS - 1));
    assign state_o    = state;

    always_comb begin
        cur_idx = '0;
        cur_val = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (k == IDX_W'(i)) begin
                cur_idx = exp_idx_i[5*i +: 5];
                cur_val = exp_val_i[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign rf_raddr_o = (state == S_CHECK) ? cur_idx : 5'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            k             <= '0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            fail_code_o   <= FC_NONE;
            fail_idx_o    <= '0;
            cycle_count_o <= '0;
        end else if (enter_run) begin
            state         <= S_RUN;
            k             <= '0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            fail_code_o   <= FC_NONE;
            fail_idx_o    <= '0;
            cycle_count_o <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (cycle_count_o != 32'hFFFF_FFFF) begin
                        cycle_count_o <= cycle_count_o + 32'd1;
                    end
                    // A halt in the timeout cycle still counts as a halt.
                    if (halt) begin
                        if (dmem_wdata_i == DATA_WIDTH'(1)) begin
                            state <= S_CHECK;
                        end else begin
                            state       <= S_DONE;
                            done_o      <= 1'b1;
                            fail_code_o <= FC_PROGRAM;
                            fail_idx_o  <= '0;
                        end
                    end else if (timeout) begin
                        state       <= S_DONE;
                        done_o      <= 1'b1;
                        fail_code_o <= FC_TIMEOUT;
                    end
                end
                S_CHECK: begin
                    if (rf_rdata_i != cur_val) begin
                        state       <= S_DONE;
                        done_o      <= 1'b1;
                        fail_code_o <= FC_MISMATCH;
                        fail_idx_o  <= k;
                    end else if (last_check) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                        pass_o <= 1'b1;
                    end else begin
                        k <= k + IDX_W'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

`ifdef JEDRO_1_TEST_MONITOR_WRCOUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_wr_count_o <= '0;
        end else if (enter_run) begin
            dmem_wr_count_o <= '0;
        end else if (state == S_RUN && dmem_we_i && dmem_wr_count_o != 32'hFFFF_FFFF) begin
            dmem_wr_count_o <= dmem_wr_count_o + 32'd1;
        end
    end
`else
    assign dmem_wr_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_jedro_1_test_monitor.sv
// Directed bench for jedro_1_test_monitor: one instance with a long timeout, one with TIMEOUT_CYCLES=16.
// Expected dmem_wr_count_o follows JEDRO_1_TEST_MONITOR_WRCOUNT_EN.
module tb_jedro_1_test_monitor;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NC = 2;
`ifdef JEDRO_1_TEST_MONITOR_WRCOUNT_EN
  localparam bit WR_ON = 1'b1;
`else
  localparam bit WR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [NC*5-1:0] exp_idx;
  logic [NC*DW-1:0] exp_val;
  logic [DW-1:0] rf [32];

  logic [4:0] a_raddr, b_raddr;
  logic [DW-1:0] a_rdata, b_rdata;
  logic a_done, b_done, a_pass, b_pass;
  logic [1:0] a_code, b_code, a_state, b_state;
  logic [1:0] a_idx, b_idx;
  logic [31:0] a_cc, b_cc, a_wr, b_wr;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  assign a_rdata = rf[a_raddr];
  assign b_rdata = rf[b_raddr];

  jedro_1_test_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHECKS(NC),
                         .TIMEOUT_CYCLES(1024), .TOHOST_ADDR(32'h0000_1000)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dmem_we_i(dmem_we),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .exp_idx_i(exp_idx),
    .exp_val_i(exp_val), .rf_raddr_o(a_raddr), .rf_rdata_i(a_rdata),
    .done_o(a_done), .pass_o(a_pass), .fail_code_o(a_code), .fail_idx_o(a_idx),
    .cycle_count_o(a_cc), .dmem_wr_count_o(a_wr), .state_o(a_state)
  );

  jedro_1_test_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHECKS(NC),
                         .TIMEOUT_CYCLES(16), .TOHOST_ADDR(32'h0000_1000)) dut_to (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dmem_we_i(dmem_we),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .exp_idx_i(exp_idx),
    .exp_val_i(exp_val), .rf_raddr_o(b_raddr), .rf_rdata_i(b_rdata),
    .done_o(b_done), .pass_o(b_pass), .fail_code_o(b_code), .fail_idx_o(b_idx),
    .cycle_count_o(b_cc), .dmem_wr_count_o(b_wr), .state_o(b_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change 1ns after the rising edge, outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] wd);
    dmem_we = 1'b1;
    dmem_addr = addr;
    dmem_wdata = wd;
    tick();
    dmem_we = 1'b0;
    dmem_addr = '0;
    dmem_wdata = '0;
  endtask

  // lat counts edges from the start of the halt cycle to the first done_o=1 sample.
  task automatic halt_and_wait_a(input logic [31:0] wd, output int lat);
    drive_write(32'h0000_1000, wd);
    lat = 1;
    while (!a_done && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(2);
    n_tests++; if ({a_done, a_pass, a_code, a_idx, a_raddr, a_state} !== 13'd0) begin n_fail++; $display("FAIL reset_flags: got %h exp 0", {a_done, a_pass, a_code, a_idx, a_raddr, a_state}); end
    n_tests++; if (a_cc !== 32'd0) begin n_fail++; $display("FAIL reset_cycle_count: got %0d exp 0", a_cc); end
    n_tests++; if (a_wr !== 32'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d exp 0", a_wr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    int lat;
    start_run();
    n_tests++; if (a_state !== 2'd1) begin n_fail++; $display("FAIL pass_in_run: got %0d exp 1", a_state); end
    idle_cycles(19);
    halt_and_wait_a(32'd1, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL pass_latency: got %0d exp 3", lat); end
    n_tests++; if ({a_done, a_pass, a_code} !== 4'b1100) begin n_fail++; $display("FAIL pass_result: got %b exp 1100", {a_done, a_pass, a_code}); end
    n_tests++; if (a_cc !== 32'd20) begin n_fail++; $display("FAIL pass_cycle_count: got %0d exp 20", a_cc); end
    idle_cycles(5);
    n_tests++; if ({a_done, a_pass, a_cc} !== {2'b11, 32'd20}) begin n_fail++; $display("FAIL pass_hold: got done=%b pass=%b cc=%0d exp 1 1 20", a_done, a_pass, a_cc); end
  endtask

  task automatic test_mismatch();
    int lat;
    rf[2] = 32'd6;
    start_run();
    n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL mismatch_done_cleared: got %b exp 0", a_done); end
    idle_cycles(19);
    halt_and_wait_a(32'd1, lat);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL mismatch_latency: got %0d exp 3", lat); end
    n_tests++; if ({a_pass, a_code, a_idx} !== 5'b0_11_01) begin n_fail++; $display("FAIL mismatch_result: got pass=%b code=%0d idx=%0d exp 0 3 1", a_pass, a_code, a_idx); end
    rf[2] = 32'd14;
  endtask

  task automatic test_program_fail();
    int lat;
    bit bad;
    bad = 1'b0;
    start_run();
    idle_cycles(19);
    drive_write(32'h0000_1000, 32'h5);
    lat = 1;
    while (!a_done && lat < 64) begin
      if (a_raddr !== 5'd0) bad = 1'b1;
      tick();
      lat++;
    end
    repeat (3) begin
      if (a_raddr !== 5'd0 || a_state === 2'd2) bad = 1'b1;
      tick();
    end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL progfail_latency: got %0d exp 1", lat); end
    n_tests++; if ({a_pass, a_code, a_idx} !== 5'b0_10_00) begin n_fail++; $display("FAIL progfail_result: got pass=%b code=%0d idx=%0d exp 0 2 0", a_pass, a_code, a_idx); end
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL progfail_no_check: got %b exp 0", bad); end
  endtask

  task automatic test_timeout();
    int n;
    start_run();
    n = 0;
    while (!b_done && n < 64) begin
      tick();
      n++;
    end
    n_tests++; if (n !== 16) begin n_fail++; $display("FAIL timeout_latency: got %0d exp 16", n); end
    n_tests++; if ({b_pass, b_code} !== 3'b001) begin n_fail++; $display("FAIL timeout_code: got pass=%b code=%0d exp 0 1", b_pass, b_code); end
    n_tests++; if (b_cc !== 32'd16) begin n_fail++; $display("FAIL timeout_cycle_count: got %0d exp 16", b_cc); end
    start_run();
    idle_cycles(15);
    n_tests++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL timeout_edge_not_done: got %b exp 0", b_done); end
    drive_write(32'h0000_1000, 32'd1);
    n_tests++; if (b_state !== 2'd2) begin n_fail++; $display("FAIL timeout_edge_check: got state %0d exp 2", b_state); end
    n = 1;
    while (!b_done && n < 64) begin
      tick();
      n++;
    end
    n_tests++; if ({b_pass, b_code, b_cc} !== {3'b100, 32'd16}) begin n_fail++; $display("FAIL timeout_edge_result: got pass=%b code=%0d cc=%0d exp 1 0 16", b_pass, b_code, b_cc); end
  endtask

  task automatic test_robust();
    int lat;
    start_run();
    idle_cycles(4);
    drive_write(32'h0000_0FFC, 32'd1);
    idle_cycles(2);
    start_run();
    idle_cycles(3);
    n_tests++; if ({a_done, a_state} !== 3'b0_01) begin n_fail++; $display("FAIL robust_still_run: got done=%b state=%0d exp 0 1", a_done, a_state); end
    halt_and_wait_a(32'd1, lat);
    n_tests++; if ({a_pass, a_cc} !== {1'b1, 32'd12}) begin n_fail++; $display("FAIL robust_result: got pass=%b cc=%0d exp 1 12", a_pass, a_cc); end
    n_tests++; if (a_wr !== (WR_ON ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL robust_wr_count: got %0d exp %0d", a_wr, WR_ON ? 2 : 0); end
  endtask

  task automatic test_reset_in_check();
    int lat;
    start_run();
    idle_cycles(4);
    drive_write(32'h0000_1000, 32'd1);
    n_tests++; if (a_raddr !== 5'd1) begin n_fail++; $display("FAIL rstchk_raddr: got %0d exp 1", a_raddr); end
    rst = 1'b1;
    tick();
    n_tests++; if ({a_done, a_pass, a_code, a_idx, a_raddr, a_state, a_cc, a_wr} !== 77'd0) begin n_fail++; $display("FAIL rstchk_zero: got done=%b pass=%b code=%0d idx=%0d raddr=%0d state=%0d cc=%0d wr=%0d exp all 0", a_done, a_pass, a_code, a_idx, a_raddr, a_state, a_cc, a_wr); end
    rst = 1'b0;
    start_run();
    idle_cycles(5);
    halt_and_wait_a(32'd1, lat);
    n_tests++; if ({a_pass, a_code, a_cc} !== {3'b100, 32'd6}) begin n_fail++; $display("FAIL rstchk_fresh: got pass=%b code=%0d cc=%0d exp 1 0 6", a_pass, a_code, a_cc); end
  endtask

  task automatic test_index0();
    int lat;
    exp_idx = {5'd2, 5'd0};
    exp_val = {32'd14, 32'd0};
    start_run();
    idle_cycles(2);
    halt_and_wait_a(32'd1, lat);
    n_tests++; if ({a_pass, a_code} !== 3'b100) begin n_fail++; $display("FAIL x0_pass: got pass=%b code=%0d exp 1 0", a_pass, a_code); end
    exp_val = {32'd14, 32'd5};
    start_run();
    idle_cycles(2);
    halt_and_wait_a(32'd1, lat);
    n_tests++; if ({lat, a_code, a_idx} !== {32'd2, 2'd3, 2'd0}) begin n_fail++; $display("FAIL x0_mismatch: got lat=%0d code=%0d idx=%0d exp 2 3 0", lat, a_code, a_idx); end
    exp_idx = {5'd2, 5'd1};
    exp_val = {32'd14, 32'd14};
  endtask

  task automatic test_wrcount();
    int lat;
    start_run();
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_write(32'h0000_2000 + 32'(4 * i), 32'(i));
    end
    tick();
    halt_and_wait_a(32'd1, lat);
    n_tests++; if (a_wr !== (WR_ON ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL wrcount_value: got %0d exp %0d", a_wr, WR_ON ? 4 : 0); end
    drive_write(32'h0000_2000, 32'd9);
    idle_cycles(2);
    n_tests++; if (a_wr !== (WR_ON ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL wrcount_held: got %0d exp %0d", a_wr, WR_ON ? 4 : 0); end
    start_run();
    n_tests++; if (a_wr !== 32'd0) begin n_fail++; $display("FAIL wrcount_cleared: got %0d exp 0", a_wr); end
    idle_cycles(1);
    halt_and_wait_a(32'd1, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] exp_cc, exp_code;
    int halts[3] = '{3, 5, 2};
    logic [31:0] wds[3] = '{32'd7, 32'd1, 32'd1};
    exp_q.push_back(32'd3); exp_q.push_back(32'd2);
    exp_q.push_back(32'd5); exp_q.push_back(32'd0);
    exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    for (int r = 0; r < 3; r++) begin
      start_run();
      n_tests++; if ({a_done, a_cc} !== 33'd0) begin n_fail++; $display("FAIL b2b_entry_%0d: got done=%b cc=%0d exp 0 0", r, a_done, a_cc); end
      idle_cycles(halts[r] - 1);
      halt_and_wait_a(wds[r], lat);
      exp_cc = exp_q.pop_front();
      exp_code = exp_q.pop_front();
      n_tests++; if ({a_cc, 30'd0, a_code} !== {exp_cc, exp_code}) begin n_fail++; $display("FAIL b2b_result_%0d: got cc=%0d code=%0d exp %0d %0d", r, a_cc, a_code, exp_cc, exp_code); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dmem_we = 1'b0;
    dmem_addr = '0;
    dmem_wdata = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3 + 100);
    rf[0] = 32'd0;
    rf[1] = 32'd14;
    rf[2] = 32'd14;
    exp_idx = {5'd2, 5'd1};
    exp_val = {32'd14, 32'd14};
    test_reset();
    test_pass();
    test_mismatch();
    test_program_fail();
    test_timeout();
    test_robust();
    test_reset_in_check();
    test_index0();
    test_wrcount();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
